// File: rtl/target_generator.sv
// target_generator: pseudo-random target cell source and score keeper for the snake controller.
// Define TARGET_LFSR_FREERUN_EN to let both LFSRs step every cycle instead of only while generating.
module target_generator #(
    parameter int           MAX_X       = 159,
    parameter int           MAX_Y       = 119,
    parameter int           INIT_X      = 40,
    parameter int           INIT_Y      = 30,
    parameter logic [7:0]   SEED_X      = 8'hA5,
    parameter logic [6:0]   SEED_Y      = 7'h35,
    parameter int           MAX_TRIES   = 32,
    parameter int           TARGET_GOAL = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] M_STATE,
    input  logic       REACHED,
    output logic [7:0] TARGET_H,
    output logic [6:0] TARGET_V,
    output logic       TARGET_VALID,
    output logic [3:0] SCORE,
    output logic       WIN
);
    localparam logic [7:0] MX   = 8'(MAX_X);
    localparam logic [6:0] MY   = 7'(MAX_Y);
    localparam logic [3:0] GOAL = 4'(TARGET_GOAL);
    localparam logic [4:0] LAST = 5'(MAX_TRIES - 1);

    typedef enum logic {IDLE, GEN} state_t;
    state_t state;

    logic [7:0] lx, cx;
    logic [6:0] ly, cy;
    logic [4:0] tries;
    logic [8:0] sum_h;
    logic [7:0] sum_v;
    logic       accept, hit, step;

    always_comb begin
        cx     = lx - 8'd1;
        cy     = ly - 7'd1;
        accept = cx <= MX && cy <= MY && !(cx == TARGET_H && cy == TARGET_V);
        sum_h  = {1'b0, TARGET_H} + 9'd37;
        sum_v  = {1'b0, TARGET_V} + 8'd29;
        hit    = REACHED && M_STATE == 2'd1 && !WIN;
    end

`ifdef TARGET_LFSR_FREERUN_EN
    assign step = 1'b1;
`else
    assign step = state == GEN;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            TARGET_H     <= 8'(INIT_X);
            TARGET_V     <= 7'(INIT_Y);
            TARGET_VALID <= 1'b1;
            SCORE        <= 4'd0;
            WIN          <= 1'b0;
            lx           <= SEED_X;
            ly           <= SEED_Y;
            tries        <= 5'd0;
        end else begin
            if (step) begin
                lx <= {lx[6:0], lx[7] ^ lx[5] ^ lx[4] ^ lx[3]};
                ly <= {ly[5:0], ly[6] ^ ly[5]};
            end
            if (state == IDLE) begin
                if (hit) begin
                    state        <= GEN;
                    TARGET_VALID <= 1'b0;
                    tries        <= 5'd0;
                    SCORE        <= SCORE == GOAL ? SCORE : SCORE + 4'd1;
                    WIN          <= SCORE + 4'd1 == GOAL;
                end
            end else if (accept) begin
                state        <= IDLE;
                TARGET_H     <= cx;
                TARGET_V     <= cy;
                TARGET_VALID <= 1'b1;
            end else if (tries == LAST) begin
                // Give up on the LFSRs and hop by a fixed stride so latency stays bounded.
                state        <= IDLE;
                TARGET_H     <= 8'(sum_h % 9'(MAX_X + 1));
                TARGET_V     <= 7'(sum_v % 8'(MAX_Y + 1));
                TARGET_VALID <= 1'b1;
            end else begin
                tries <= tries + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_target_generator.sv
// tb_target_generator: scoreboard bench for target_generator, plus a small-grid instance for the fallback path.
module tb_target_generator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] m_state = 2'd1;
    logic       reached = 1'b0;
    logic       f_reached = 1'b0;
    logic [7:0] th, f_th;
    logic [6:0] tv, f_tv;
    logic       tvalid, f_tvalid, win, f_win;
    logic [3:0] score, f_score;

    int total = 0;
    int passed = 0;

    logic [7:0] m_lx, m_h;
    logic [6:0] m_ly, m_v;
    int         m_s;

    typedef struct {
        logic [7:0] h;
        logic [6:0] v;
        logic [3:0] s;
        logic       w;
        int         lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    target_generator dut (
        .CLK(clk), .RESET(rst), .M_STATE(m_state), .REACHED(reached),
        .TARGET_H(th), .TARGET_V(tv), .TARGET_VALID(tvalid), .SCORE(score), .WIN(win)
    );

    target_generator #(.MAX_X(3), .INIT_X(2), .MAX_TRIES(1)) fdut (
        .CLK(clk), .RESET(rst), .M_STATE(m_state), .REACHED(f_reached),
        .TARGET_H(f_th), .TARGET_V(f_tv), .TARGET_VALID(f_tvalid), .SCORE(f_score), .WIN(f_win)
    );

    task automatic model_reset();
        m_lx = 8'hA5;
        m_ly = 7'h35;
        m_h  = 8'd40;
        m_v  = 7'd30;
        m_s  = 0;
    endtask

    task automatic model_gen(output int lat);
        logic [7:0] cx;
        logic [6:0] cy;
        lat = 0;
        for (int i = 0; i < 32; i++) begin
            cx = m_lx - 8'd1;
            cy = m_ly - 7'd1;
            lat++;
            m_lx = {m_lx[6:0], m_lx[7] ^ m_lx[5] ^ m_lx[4] ^ m_lx[3]};
            m_ly = {m_ly[5:0], m_ly[6] ^ m_ly[5]};
            if (cx <= 8'd159 && cy <= 7'd119 && !(cx == m_h && cy == m_v)) begin
                m_h = cx;
                m_v = cy;
                return;
            end
        end
        m_h = 8'((m_h + 37) % 160);
        m_v = 7'((m_v + 29) % 120);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        reached = 1'b0;
        f_reached = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic run_target(input int hold);
        exp_t e;
        int k;
        model_gen(e.lat);
        if (m_s < 10) m_s++;
        e.h = m_h;
        e.v = m_v;
        e.s = 4'(m_s);
        e.w = m_s == 10;
        sb.push_back(e);
        @(negedge clk) reached = 1'b1;
        repeat (hold) @(negedge clk);
        reached = 1'b0;
        k = hold - 1;
        total++;
        if (tvalid !== 1'b0) $display("FAIL valid_low_after_hit: got %b want 0", tvalid);
        else passed++;
        while (!tvalid && k < 40) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        total++;
        if (k !== e.lat) $display("FAIL latency: got %0d want %0d", k, e.lat);
        else passed++;
        total++;
        if ({th, tv, score, win} !== {e.h, e.v, e.s, e.w})
            $display("FAIL target: got h=%0d v=%0d s=%0d w=%b want h=%0d v=%0d s=%0d w=%b",
                     th, tv, score, win, e.h, e.v, e.s, e.w);
        else passed++;
    endtask

    task automatic check_still(input string name, input logic [7:0] h, input logic [6:0] v, input logic [3:0] s, input logic w);
        total++;
        if ({th, tv, tvalid, score, win} !== {h, v, 1'b1, s, w})
            $display("FAIL %s: got h=%0d v=%0d valid=%b s=%0d w=%b want h=%0d v=%0d valid=1 s=%0d w=%b",
                     name, th, tv, tvalid, score, win, h, v, s, w);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset();
        check_still("reset", 8'd40, 7'd30, 4'd0, 1'b0);
    endtask

    task automatic test_first_target();
        run_target(1);
        check_still("first_target", 8'd73, 7'd106, 4'd1, 1'b0);
    endtask

    task automatic test_ignored();
        m_state = 2'd0;
        @(negedge clk) reached = 1'b1;
        @(negedge clk) reached = 1'b0;
        repeat (3) @(negedge clk);
        check_still("ignored_mstate", 8'd73, 7'd106, 4'd1, 1'b0);
        m_state = 2'd1;
        do_reset();
        run_target(2);
        check_still("ignored_in_gen", 8'd73, 7'd106, 4'd1, 1'b0);
    endtask

    task automatic test_win();
        do_reset();
        for (int i = 0; i < 10; i++) run_target(1);
        check_still("win", m_h, m_v, 4'd10, 1'b1);
        @(negedge clk) reached = 1'b1;
        @(negedge clk) reached = 1'b0;
        check_still("after_win_t", m_h, m_v, 4'd10, 1'b1);
        repeat (3) @(negedge clk);
        check_still("after_win_t3", m_h, m_v, 4'd10, 1'b1);
    endtask

    task automatic test_fallback();
        logic [7:0] eh;
        logic [6:0] ev;
        do_reset();
        eh = 8'd2;
        ev = 7'd30;
        for (int i = 0; i < 2; i++) begin
            eh = 8'((eh + 37) % 4);
            ev = 7'((ev + 29) % 120);
            @(negedge clk) f_reached = 1'b1;
            @(negedge clk) f_reached = 1'b0;
            total++;
            if (f_tvalid !== 1'b0) $display("FAIL fallback_valid_low: got %b want 0", f_tvalid);
            else passed++;
            @(negedge clk);
            total++;
            if ({f_th, f_tv, f_tvalid} !== {eh, ev, 1'b1})
                $display("FAIL fallback: got h=%0d v=%0d valid=%b want h=%0d v=%0d valid=1", f_th, f_tv, f_tvalid, eh, ev);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_gen();
        do_reset();
        run_target(1);
        @(negedge clk) reached = 1'b1;
        @(negedge clk) begin
            reached = 1'b0;
            rst = 1'b1;
        end
        @(negedge clk) rst = 1'b0;
        check_still("reset_mid_gen", 8'd40, 7'd30, 4'd0, 1'b0);
        model_reset();
        run_target(1);
        check_still("after_mid_gen_reset", 8'd73, 7'd106, 4'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_first_target();
        test_ignored();
        test_win();
        test_fallback();
        test_reset_mid_gen();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/target_generator.md
# target_generator

Produces the target cell coordinates the snake controller chases, and issues a fresh pseudo-random target each time the controller reports a hit on its `REACHED` output. The snake controller is the initiator; this block is the responder and also keeps the score. It sits between the game master-state machine and the snake controller. Its `TARGET_H`/`TARGET_V` outputs drive the controller's target inputs and the VGA colour path directly, on the 160x120 cell grid.

## Interface
Parameters:
- `MAX_X`, 159: largest legal horizontal cell index.
- `MAX_Y`, 119: largest legal vertical cell index.
- `INIT_X`, 40: `TARGET_H` value after reset.
- `INIT_Y`, 30: `TARGET_V` value after reset.
- `SEED_X`, 8'hA5: X LFSR reset value; must be non-zero.
- `SEED_Y`, 7'h35: Y LFSR reset value; must be non-zero.
- `MAX_TRIES`, 32: number of rejected GEN cycles before the fallback rule is used.
- `TARGET_GOAL`, 10: score at which `WIN` asserts.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-high.
- `M_STATE` in 2: game state; 2'd1 = play.
- `REACHED` in 1: single-cycle hit pulse from the snake controller.
- `TARGET_H` out 8: target X cell.
- `TARGET_V` out 7: target Y cell.
- `TARGET_VALID` out 1: high while the target outputs are stable and final.
- `SCORE` out 4: number of targets eaten; saturates at `TARGET_GOAL`.
- `WIN` out 1: sticky; high once `SCORE == TARGET_GOAL`.

## Operation
- **X LFSR:** 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, period 255. Step: `lx <= {lx[6:0], lx[7]^lx[5]^lx[4]^lx[3]}`.
- **Y LFSR:** 7-bit, polynomial x^7+x^6+1, period 127. Step: `ly <= {ly[5:0], ly[6]^ly[5]}`.
- **Candidates:** `cx = lx - 1` (range 0..254), `cy = ly - 1` (range 0..126). Both are combinational from the current register values.
- **Accept condition:** `cx <= MAX_X` and `cy <= MAX_Y` and `(cx, cy) != (TARGET_H, TARGET_V)`.
- **FSM states:**
  - IDLE: `TARGET_VALID = 1`. A `REACHED` pulse with `M_STATE == 1` and `WIN == 0` moves to GEN, clears `TARGET_VALID`, increments `SCORE` (saturating) and clears the try counter.
  - GEN: evaluates the candidates every cycle, then steps both LFSRs on the same edge. On accept: load `TARGET_H <= cx`, `TARGET_V <= cy`, set `TARGET_VALID`, go to IDLE. On reject: increment the 5-bit try counter and stay in GEN.
  - Fallback: when the try counter reaches `MAX_TRIES-1` and the candidate is still rejected, load `TARGET_H <= (TARGET_H+37) mod (MAX_X+1)` and `TARGET_V <= (TARGET_V+29) mod (MAX_Y+1)`, then go to IDLE. Compute these in 9-bit/8-bit arithmetic before the compare-and-subtract.
- **WIN:** asserts on the same edge that `SCORE` becomes `TARGET_GOAL`. Once `WIN` is high, further `REACHED` pulses are ignored: no GEN, no score change.
- **Ignored REACHED:** a `REACHED` pulse while in GEN, or while `M_STATE != 1`, is ignored.
- **M_STATE change during GEN:** if `M_STATE` leaves 1 during GEN, GEN still runs to completion.
- **Reset:** `RESET` at any point, including mid-GEN, forces the following on the next edge:
  - state IDLE;
  - `TARGET_H = INIT_X`, `TARGET_V = INIT_Y`, `TARGET_VALID = 1`;
  - `SCORE = 0`, `WIN = 0`;
  - `lx = SEED_X`, `ly = SEED_Y`, try counter = 0.

## Timing
- `REACHED` is sampled at edge t. `TARGET_VALID` is low from t onward.
- Earliest target update is at edge t+1 (accept on the first GEN cycle), so `TARGET_VALID` is low for at least 1 cycle.
- Worst-case latency is `MAX_TRIES` cycles (fallback).
- `SCORE` updates at edge t. All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `TARGET_LFSR_FREERUN_EN` defined: both LFSRs step every non-reset cycle in every state. Target positions then depend on the player's timing.
- Not defined: the LFSRs step only in GEN. The target sequence is fully deterministic from the seeds; this is the mode used for regression.

## Test plan
- **Reset values:** assert `RESET` for 2 cycles -> `TARGET_H=40`, `TARGET_V=30`, `TARGET_VALID=1`, `SCORE=0`, `WIN=0`.
- **First target, macro off, default seeds:** with `M_STATE=1`, pulse `REACHED` at edge t.
  - Edge t+1: `cx=164` is rejected.
  - Edge t+2: `TARGET_H=73`, `TARGET_V=106`, `TARGET_VALID=1`, `SCORE=1`.
- **Ignored pulses:** `REACHED` with `M_STATE=0` -> no change to any output. A second `REACHED` at t+1 while in GEN -> `SCORE` stays 1.
- **Win and saturation:** 10 accepted `REACHED` pulses -> `SCORE=10`, `WIN=1`. An 11th pulse -> `SCORE=10`, targets unchanged, `TARGET_VALID` stays 1.
- **Fallback:** with `MAX_TRIES=1` and `MAX_X=3`, force repeated rejection -> target advances to `((H+37) mod 4, (V+29) mod (MAX_Y+1))` after 1 GEN cycle.
- **Reset mid-GEN:** assert `RESET` at t+1 after a `REACHED` -> next edge restores all reset values, and the following `REACHED` again yields (73,106).
